// File: rtl/branch_unit_ras.sv
// branch_unit_ras: registered next-PC unit with a circular return-address stack.
// Resolves jmp/bcond/call/jr/halt/ret, owns the PC and a latched copy of the ALU flags.
module branch_unit_ras #(
    parameter int              XLEN      = 32,
    parameter int              RAS_DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            upd_en,
    input  logic [2:0]      br_type,
    input  logic [5:0]      func,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] des_addr,
    input  logic [2:0]      flag_in,
    input  logic            flag_we,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] link_addr,
    output logic            link_we,
    output logic            halted,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_ovf,
    output logic            ras_unf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] BR_JMP   = 3'b001;
    localparam logic [2:0] BR_BCOND = 3'b010;
    localparam logic [2:0] BR_CALL  = 3'b011;
    localparam logic [2:0] BR_JR    = 3'b100;
    localparam logic [2:0] BR_HALT  = 3'b101;
    localparam logic [2:0] BR_RET   = 3'b110;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_link_addr;
    logic            r_link_we;
    logic            r_halted;
    logic            r_ovf;
    logic            r_unf;
    logic [2:0]      r_flag_q;
    logic [PW-1:0]   r_wp;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_mem [RAS_DEPTH];

    logic            w_active;
    logic            w_empty;
    logic            w_full;
    logic [PW-1:0]   w_wp_dec;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_next_pc;
    logic            w_push;
    logic            w_pop;
    logic            w_halt;
    logic            w_unf;

    assign w_active = upd_en & ~r_halted;
    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == CW'(RAS_DEPTH));
    assign w_wp_dec = r_wp - 1'b1;
    assign w_pc_inc = r_pc + 1'b1;

    // Decode the branch type into the next PC and the stack/halt side effects.
    always_comb begin
        w_next_pc = w_pc_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_halt    = 1'b0;
        w_unf     = 1'b0;
        case (br_type)
            BR_JMP: begin
                if (func == 6'd0) w_next_pc = imm;
            end
            BR_BCOND: begin
                if (func <= 6'd2 && r_flag_q[func[1:0]]) w_next_pc = r_pc + imm;
            end
            BR_CALL: begin
                if (func == 6'd0) begin
                    w_next_pc = r_pc + imm;
                    w_push    = 1'b1;
                end
            end
            BR_JR: begin
                if (func == 6'd0) w_next_pc = des_addr;
            end
            BR_HALT: begin
                if (func == 6'd0) begin
                    w_next_pc = r_pc;
                    w_halt    = 1'b1;
                end
            end
            BR_RET: begin
                if (func == 6'd0) begin
                    if (w_empty) begin
                        w_unf = 1'b1;
                    end else begin
                        w_pop     = 1'b1;
                        w_next_pc = r_mem[w_wp_dec];
                    end
                end
            end
            default: ;
        endcase
    end

    // Architectural PC, link register, sticky halt, one-cycle pulses and flag latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_link_addr <= '0;
            r_link_we   <= 1'b0;
            r_halted    <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_flag_q    <= '0;
        end else begin
            r_link_we <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            if (flag_we) r_flag_q <= flag_in;
            if (w_active) begin
                r_pc <= w_next_pc;
                if (w_halt) r_halted <= 1'b1;
                if (w_push) begin
                    r_link_addr <= w_pc_inc;
                    r_link_we   <= 1'b1;
                    r_ovf       <= w_full;
                end
                r_unf <= w_unf;
            end
        end
    end

    // Stack pointer and occupancy; a push while full overwrites the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_cnt <= '0;
        end else if (w_active) begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
                if (!w_full) r_cnt <= r_cnt + 1'b1;
            end else if (w_pop) begin
                r_wp  <= w_wp_dec;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Stack storage is never cleared; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_active && w_push) r_mem[r_wp] <= w_pc_inc;
    end

    assign pc        = r_pc;
    assign link_addr = r_link_addr;
    assign link_we   = r_link_we;
    assign halted    = r_halted;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;

endmodule
